// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types for the data-memory arbiter.
// Owner states, memory depth and the port-index type used by the picker.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam int DMEM_WORDS = 64;

  // 0 = processor data port, 1 = loader/DMA port
  typedef logic port_t;

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational two-requester round-robin picker.
// On a tie the port that was not served last wins; with a single requester
// that requester wins. The output is don't-care when nobody requests.
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic  req0,
  input  logic  req1,
  input  port_t last,
  output port_t win
);

  assign win = (req0 & req1) ? port_t'(~last) : port_t'(req1);

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the processor
// data port (0) and the loader/DMA port (1), one word access per clock,
// round-robin with a burst limit of BURST_MAX grants while contended.
// Optional feature macro: DMEM_ARB_BOUNDS_CHECK_EN -- accesses with any
// address bit above bit 7 set are granted but do not write, read back 0
// and raise a one-cycle err pulse. DATA_W must be at least 9.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int BURST_MAX = 4,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [DATA_W-1:0] addr0,
  input  logic [DATA_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd,
  output logic              err
);

  localparam int                CNT_W   = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(BURST_MAX - 1);

  state_t           state;
  port_t            last;
  logic [CNT_W-1:0] cnt;

  port_t pick_last;
  port_t win;
  logic  own_req;
  logic  oth_req;
  logic  stay;
  logic  ok0;
  logic  ok1;

`ifdef DMEM_ARB_BOUNDS_CHECK_EN
  assign ok0 = ~(|addr0[DATA_W-1:8]);
  assign ok1 = ~(|addr1[DATA_W-1:8]);
`else
  assign ok0 = 1'b1;
  assign ok1 = 1'b1;
`endif

  // In IDLE the tie-break uses the last served port; when leaving an owner
  // state the current owner counts as "last" so the other side wins a tie.
  assign pick_last = (state == IDLE) ? last : port_t'(state == OWN1);

  rr_pick2 u_pick (
    .req0 (req0),
    .req1 (req1),
    .last (pick_last),
    .win  (win)
  );

  // Grants, memory drive and the keep-ownership decision
  always_comb begin
    gnt0    = (state == OWN0) & req0;
    gnt1    = (state == OWN1) & req1;
    own_req = (state == OWN0) ? req0 : req1;
    oth_req = (state == OWN0) ? req1 : req0;
    stay    = own_req & (~oth_req | (cnt < CNT_MAX));
    mem_we  = (gnt0 & we0 & ok0) | (gnt1 & we1 & ok1);
    mem_a   = '0;
    mem_wd  = '0;
    if (gnt0) begin
      mem_a  = addr0;
      mem_wd = wdata0;
    end else if (gnt1) begin
      mem_a  = addr1;
      mem_wd = wdata1;
    end
  end

  // Ownership FSM, burst counter and last-served tracking
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      last  <= 1'b1;
      cnt   <= '0;
    end else begin
      if (gnt0)      last <= 1'b0;
      else if (gnt1) last <= 1'b1;
      case (state)
        IDLE: begin
          if (req0 | req1) state <= win ? OWN1 : OWN0;
          cnt <= '0;
        end
        OWN0, OWN1: begin
          if (stay) begin
            if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
          end else if (req0 | req1) begin
            state <= win ? OWN1 : OWN0;
            cnt   <= '0;
          end else begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Capture read data for the port that completed a read this cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= gnt0 & ~we0;
      rvalid1 <= gnt1 & ~we1;
      if (gnt0 & ~we0) rdata0 <= ok0 ? mem_rd : '0;
      if (gnt1 & ~we1) rdata1 <= ok1 ? mem_rd : '0;
    end
  end

`ifdef DMEM_ARB_BOUNDS_CHECK_EN
  // Flag an out-of-range access one cycle after its grant
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err <= 1'b0;
    else          err <= (gnt0 & ~ok0) | (gnt1 & ~ok1);
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter sharing the single-port data memory (64 × 32-bit words, combinational read, write on rising clk) between the processor data port (port 0) and a loader/DMA port (port 1). It sequences one word access per clock with round-robin priority and a bounded burst length. It sits between the requesters and `dmem` inside `top`, and drives the memory's `we`, `a` and `wd` and consumes its `rd`.

## Interface
- `BURST_MAX`, default 4: maximum consecutive granted accesses to one port while the other is requesting (≥1).
- `DATA_W`, default 32: data and address width.
- `clk`  input  1  single clock; all state changes on the rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `req0`, `req1`  input  1  access request; held with `we`/`addr`/`wdata` stable until the matching `gnt` cycle.
- `we0`, `we1`  input  1  1 = write, 0 = read.
- `addr0`, `addr1`  input  DATA_W  byte address; word index is `addr[7:2]`.
- `wdata0`, `wdata1`  input  DATA_W  write data.
- `gnt0`, `gnt1`  output  1  access performed this cycle (write commits at the closing edge).
- `rvalid0`, `rvalid1`  output  1  one-cycle pulse; `rdata` holds the read result.
- `rdata0`, `rdata1`  output  DATA_W  registered read data per port.
- `mem_we`  output  1; `mem_a`  output  DATA_W; `mem_wd`  output  DATA_W  memory drive.
- `mem_rd`  input  DATA_W  memory read data.
- `err`  output  1  out-of-range pulse (see Configuration).

## Operation
- FSM states: IDLE, OWN0, OWN1. Registers: `state`, `last` (last served port), `cnt` (burst count, saturating at BURST_MAX-1).
- `gnt0 = (state==OWN0) & req0`; `gnt1 = (state==OWN1) & req1`. Memory is driven from the owning port; `mem_we = gnt_k & we_k`. In IDLE, or when the owner is not requesting, `mem_we=0` and `mem_a`/`mem_wd` are 0.
- IDLE: if only one port requests, go to its OWN; if both request, go to OWN of the port ≠ `last`; `cnt←0`.
- OWNk, at end of cycle:
  - neither port requesting → IDLE;
  - only the other port requesting → OWN(other), `cnt←0`;
  - only k requesting → stay, `cnt` increments, saturating;
  - both requesting → stay if `cnt < BURST_MAX-1`, else OWN(other) with `cnt←0`.
- `last←k` on every edge that ends a `gnt_k` cycle.
- Read: on the edge ending a `gnt_k & !we_k` cycle, `rdata_k←mem_rd` and `rvalid_k←1` for one cycle. `rdata_k` otherwise holds its value.
- Each `gnt` cycle is one complete transaction. A requester keeping `req` high in the next cycle presents a new transaction.

## Timing
- Reset values: state IDLE, `last=1` (port 0 wins the first tie), `cnt=0`, `rvalid*=0`, `rdata*=0`, `err=0`. Combinational outputs follow from these: `gnt*=0`, `mem_we=0`.
- Latency from IDLE: `req` in cycle n → `gnt` in cycle n+1 → `rvalid` in cycle n+2.
- Owner back-to-back: one access per cycle, zero bubbles. Switching owner costs no dead cycle when the other port is already requesting.
- Worst-case wait for a requesting port is BURST_MAX cycles.
- `reset_n` asserted mid-access drops `gnt`/`mem_we` immediately (asynchronous), so no write commits. The interrupted transaction is lost, and the requester re-issues it after reset.

## Configuration
- `DMEM_ARB_BOUNDS_CHECK_EN` defined: an access with `addr[31:8]≠0` is still granted (the handshake completes), but `mem_we` is forced to 0. A read returns 0 into `rdata_k`, and `err` pulses one cycle after the `gnt`.
- Undefined: no checking; the address is passed through unchanged; `err` is tied to 0.

## Structure
- Package `dmem_arb_pkg`: state enum (IDLE, OWN0, OWN1), `DMEM_WORDS=64`, port-index typedef.
- One sub-module, `rr_pick2`: combinational two-requester round-robin picker (inputs `req0`, `req1`, `last`; output winner index). It is used in the IDLE and switch decisions.

## Test plan
- Reset, then `req0` write to `addr0=0x50` with `wdata0=7`: `gnt0` one cycle after `req0`, `mem_we=1`, `mem_a=0x50`; memory word 20 = 7.
- Port 1 reads 0x50 after that write: `gnt1`, then next cycle `rvalid1=1`, `rdata1=7`.
- Both ports hold `req` high from reset with BURST_MAX=4: grants go port 0 ×4, then port 1 ×4, alternating; no cycle without a grant.
- Port 0 alone requests 10 cycles, then port 1 joins: port 1 is granted within 4 cycles; `cnt` never exceeds 3.
- `reset_n` pulled low in the middle of a port 1 write to 0x10: `gnt1`/`mem_we` drop the same cycle; word 4 is unchanged.
- With `DMEM_ARB_BOUNDS_CHECK_EN`, a write to 0x100: granted, `mem_we=0`, `err` pulses one cycle later. Without the macro, `err` stays 0.
